axi_lite_to_axi_tracked: RTL and testbench

//  Converts an AXI4-Lite subordinate port into a full AXI4+ATOP manager port, so that Lite managers
//  can access full-AXI crossbars and memories. Every Lite access becomes a single-beat AXI4 burst

---
 rtl/axi_lite_to_axi_tracked.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axi_lite_to_axi_tracked.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_to_axi_tracked.sv
// AXI4-Lite subordinate to AXI4+ATOP manager bridge with per-direction outstanding-transaction caps.
// Latency: zero; every request/response path is combinational, only the counters and error flag are flops.
// Backpressure: AW/AR valid+ready close while the registered count is at its max; W, B and R pass straight through.
// Optional build macro AXI_LITE_TO_AXI_RSP_CHECK_EN adds a sticky response-protocol checker on rsp_err_o.

package axi_lite_to_axi_pkg;
  localparam int unsigned IdWidth   = 1;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned UserWidth = 1;

  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [UserWidth-1:0]   user_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    user_t      user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } full_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } full_resp_t;

  typedef struct packed { addr_t addr; logic [2:0] prot; } lite_aw_t;
  typedef struct packed { data_t data; strb_t strb; } lite_w_t;
  typedef struct packed { logic [1:0] resp; } lite_b_t;
  typedef struct packed { addr_t addr; logic [2:0] prot; } lite_ar_t;
  typedef struct packed { data_t data; logic [1:0] resp; } lite_r_t;

  typedef struct packed {
    lite_aw_t aw;
    logic     aw_valid;
    lite_w_t  w;
    logic     w_valid;
    logic     b_ready;
    lite_ar_t ar;
    logic     ar_valid;
    logic     r_ready;
  } lite_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    lite_b_t b;
    logic    b_valid;
    logic    ar_ready;
    lite_r_t r;
    logic    r_valid;
  } lite_resp_t;
endpackage

module axi_lite_to_axi_tracked #(
  parameter int unsigned AxiIdWidth      = 1,
  parameter int unsigned AxiAddrWidth    = 32,
  parameter int unsigned AxiDataWidth    = 32,
  parameter int unsigned AxiUserWidth    = 1,
  parameter int unsigned AxiMaxWriteTxns = 4,
  parameter int unsigned AxiMaxReadTxns  = 4,
  parameter int unsigned FixedId         = 0,
  parameter logic [3:0]  AxCache         = 4'b0000,
  parameter type full_req_t  = axi_lite_to_axi_pkg::full_req_t,
  parameter type full_resp_t = axi_lite_to_axi_pkg::full_resp_t,
  parameter type lite_req_t  = axi_lite_to_axi_pkg::lite_req_t,
  parameter type lite_resp_t = axi_lite_to_axi_pkg::lite_resp_t
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  lite_req_t                              slv_req_i,
  output lite_resp_t                             slv_resp_o,
  output full_req_t                              mst_req_o,
  input  full_resp_t                             mst_resp_i,
  output logic [$clog2(AxiMaxWriteTxns+1)-1:0]   wr_cnt_o,
  output logic [$clog2(AxiMaxReadTxns+1)-1:0]    rd_cnt_o,
  output logic                                   rsp_err_o
);

  localparam int unsigned WrCntWidth = $clog2(AxiMaxWriteTxns + 1);
  localparam int unsigned RdCntWidth = $clog2(AxiMaxReadTxns + 1);

  localparam logic [WrCntWidth-1:0] WrMax   = WrCntWidth'(AxiMaxWriteTxns);
  localparam logic [RdCntWidth-1:0] RdMax   = RdCntWidth'(AxiMaxReadTxns);
  localparam logic [AxiIdWidth-1:0] IdConst = AxiIdWidth'(FixedId);
  localparam logic [2:0]            AxSize  = 3'($clog2(AxiDataWidth / 8));
  localparam logic [1:0]            BurstIncr = 2'b01;

  logic [WrCntWidth-1:0] wr_cnt_q, wr_cnt_d;
  logic [RdCntWidth-1:0] rd_cnt_q, rd_cnt_d;
  logic                  wr_full, rd_full;
  logic                  aw_hs, b_hs, ar_hs, r_hs;

  // Gates use only registered counts, so a same-cycle B/R never reopens AW/AR
  // and a pending AW/AR can never be withdrawn (count only grows on its handshake).
  assign wr_full = (wr_cnt_q >= WrMax);
  assign rd_full = (rd_cnt_q >= RdMax);

  assign aw_hs = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign b_hs  = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign ar_hs = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign r_hs  = mst_resp_i.r_valid & slv_req_i.r_ready;

  // Lite request expanded into single-beat INCR bursts carrying the fixed ID.
  always_comb begin
    mst_req_o           = '0;
    mst_req_o.aw.id     = IdConst;
    mst_req_o.aw.addr   = slv_req_i.aw.addr;
    mst_req_o.aw.prot   = slv_req_i.aw.prot;
    mst_req_o.aw.size   = AxSize;
    mst_req_o.aw.burst  = BurstIncr;
    mst_req_o.aw.cache  = AxCache;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & ~wr_full;
    mst_req_o.w.data    = slv_req_i.w.data;
    mst_req_o.w.strb    = slv_req_i.w.strb;
    mst_req_o.w.last    = 1'b1;
    mst_req_o.w_valid   = slv_req_i.w_valid;
    mst_req_o.b_ready   = slv_req_i.b_ready;
    mst_req_o.ar.id     = IdConst;
    mst_req_o.ar.addr   = slv_req_i.ar.addr;
    mst_req_o.ar.prot   = slv_req_i.ar.prot;
    mst_req_o.ar.size   = AxSize;
    mst_req_o.ar.burst  = BurstIncr;
    mst_req_o.ar.cache  = AxCache;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ~rd_full;
    mst_req_o.r_ready   = slv_req_i.r_ready;
  end

  // Responses collapsed back to Lite; AW/AR ready gated identically to valid.
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~wr_full;
    slv_resp_o.w_ready  = mst_resp_i.w_ready;
    slv_resp_o.b.resp   = mst_resp_i.b.resp;
    slv_resp_o.b_valid  = mst_resp_i.b_valid;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~rd_full;
    slv_resp_o.r.data   = mst_resp_i.r.data;
    slv_resp_o.r.resp   = mst_resp_i.r.resp;
    slv_resp_o.r_valid  = mst_resp_i.r_valid;
  end

  // Outstanding counters: up on request, down on response, saturate at zero.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (aw_hs && !b_hs) begin
      wr_cnt_d = wr_cnt_q + WrCntWidth'(1);
    end else if (b_hs && !aw_hs && (wr_cnt_q != '0)) begin
      wr_cnt_d = wr_cnt_q - WrCntWidth'(1);
    end
    rd_cnt_d = rd_cnt_q;
    if (ar_hs && !r_hs) begin
      rd_cnt_d = rd_cnt_q + RdCntWidth'(1);
    end else if (r_hs && !ar_hs && (rd_cnt_q != '0)) begin
      rd_cnt_d = rd_cnt_q - RdCntWidth'(1);
    end
  end

  // Counter registers, cleared asynchronously so a reset drops all tracking at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_cnt_o = wr_cnt_q;
  assign rd_cnt_o = rd_cnt_q;

`ifdef AXI_LITE_TO_AXI_RSP_CHECK_EN
  logic rsp_err_q, rsp_err_d;

  // Sticky flag for responses that cannot belong to a request issued here.
  always_comb begin
    rsp_err_d = rsp_err_q;
    if (b_hs && ((mst_resp_i.b.id != IdConst) || (wr_cnt_q == '0))) begin
      rsp_err_d = 1'b1;
    end
    if (r_hs && ((mst_resp_i.r.id != IdConst) || !mst_resp_i.r.last || (rd_cnt_q == '0))) begin
      rsp_err_d = 1'b1;
    end
  end

  // Error flag register; only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  // Response IDs, last and user bits are not needed for routing a single fixed-ID stream.
  logic unused_rsp_fields;
  assign unused_rsp_fields = ^{mst_resp_i.b.id, mst_resp_i.b.user, mst_resp_i.r.id,
                               mst_resp_i.r.last, mst_resp_i.r.user};

endmodule

// File: tb/tb_axi_lite_to_axi_tracked.sv
// Directed bench for the Lite-to-AXI bridge: the bench plays both the Lite manager and the
// full-AXI subordinate. Expected channel payloads are queued at issue time and popped by
// per-channel monitors on each handshake; counters and gates are checked inline.
module tb_axi_lite_to_axi_tracked;
  import axi_lite_to_axi_pkg::*;

`ifdef AXI_LITE_TO_AXI_RSP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  lite_req_t  slv_req;
  lite_resp_t slv_resp;
  full_req_t  mst_req;
  full_resp_t mst_resp;
  logic [2:0] wr_cnt, rd_cnt;
  logic       rsp_err;

  int n_chk  = 0;
  int n_fail = 0;

  aw_chan_t    exp_aw[$];
  w_chan_t     exp_w[$];
  ar_chan_t    exp_ar[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  always #5 clk = ~clk;

  axi_lite_to_axi_tracked dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .wr_cnt_o   (wr_cnt),
    .rd_cnt_o   (rd_cnt),
    .rsp_err_o  (rsp_err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic aw_chan_t mk_aw(input logic [31:0] a);
    aw_chan_t e;
    e       = '0;
    e.addr  = a;
    e.size  = 3'd2;
    e.burst = 2'b01;
    return e;
  endfunction

  function automatic ar_chan_t mk_ar(input logic [31:0] a);
    ar_chan_t e;
    e       = '0;
    e.addr  = a;
    e.size  = 3'd2;
    e.burst = 2'b01;
    return e;
  endfunction

  function automatic w_chan_t mk_w(input logic [31:0] d, input logic [3:0] s);
    w_chan_t e;
    e      = '0;
    e.data = d;
    e.strb = s;
    e.last = 1'b1;
    return e;
  endfunction

  // Channel monitors: sample mid-cycle, pop the oldest expectation on each handshake.
  always @(negedge clk) begin
    if (!rst && mst_req.aw_valid && mst_resp.aw_ready) begin
      if (exp_aw.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL aw_unexpected: got addr %0h expected no AW", mst_req.aw.addr);
      end else check("aw_payload", 128'(mst_req.aw), 128'(exp_aw.pop_front()));
    end
    if (!rst && mst_req.w_valid && mst_resp.w_ready) begin
      if (exp_w.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL w_unexpected: got data %0h expected no W", mst_req.w.data);
      end else check("w_payload", 128'(mst_req.w), 128'(exp_w.pop_front()));
    end
    if (!rst && mst_req.ar_valid && mst_resp.ar_ready) begin
      if (exp_ar.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL ar_unexpected: got addr %0h expected no AR", mst_req.ar.addr);
      end else check("ar_payload", 128'(mst_req.ar), 128'(exp_ar.pop_front()));
    end
    if (!rst && slv_resp.b_valid && slv_req.b_ready) begin
      if (exp_b.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected: got resp %0h expected no B", slv_resp.b.resp);
      end else check("b_resp", 128'(slv_resp.b.resp), 128'(exp_b.pop_front()));
    end
    if (!rst && slv_resp.r_valid && slv_req.r_ready) begin
      if (exp_r.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL r_unexpected: got data %0h expected no R", slv_resp.r.data);
      end else check("r_payload", 128'({slv_resp.r.resp, slv_resp.r.data}), 128'(exp_r.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    slv_req.aw_valid = 1'b1; slv_req.aw.addr = a;
    slv_req.w_valid  = 1'b1; slv_req.w.data  = d; slv_req.w.strb = 4'hF;
    exp_aw.push_back(mk_aw(a));
    exp_w.push_back(mk_w(d, 4'hF));
    cyc();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
  endtask

  task automatic do_b(input logic id, input logic [1:0] resp);
    mst_resp.b_valid = 1'b1; mst_resp.b.id = id; mst_resp.b.resp = resp;
    exp_b.push_back(resp);
    cyc();
    mst_resp.b_valid = 1'b0; mst_resp.b.id = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a);
    slv_req.ar_valid = 1'b1; slv_req.ar.addr = a;
    exp_ar.push_back(mk_ar(a));
    cyc();
    slv_req.ar_valid = 1'b0;
  endtask

  task automatic do_r(input logic [31:0] d, input logic [1:0] resp, input logic last);
    mst_resp.r_valid = 1'b1; mst_resp.r.data = d; mst_resp.r.resp = resp;
    mst_resp.r.last  = last; mst_resp.r.id = 1'b0;
    exp_r.push_back({resp, d});
    cyc();
    mst_resp.r_valid = 1'b0; mst_resp.r.last = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    slv_req  = '0;
    mst_resp = '0;
    slv_req.b_ready   = 1'b1;
    slv_req.r_ready   = 1'b1;
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    mst_resp.ar_ready = 1'b1;
    mst_resp.r.last   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_cnt", 128'(wr_cnt), 128'(3'd0));
    check("rst_rd_cnt", 128'(rd_cnt), 128'(3'd0));
    check("rst_err", 128'(rsp_err), 128'(1'b0));
    rst = 1'b0;
    cyc();

    // Single write: AW valid is combinational straight after reset.
    slv_req.aw_valid = 1'b1; slv_req.aw.addr = 32'h100;
    slv_req.w_valid  = 1'b1; slv_req.w.data  = 32'hDEADBEEF; slv_req.w.strb = 4'hF;
    exp_aw.push_back(mk_aw(32'h100));
    exp_w.push_back(mk_w(32'hDEADBEEF, 4'hF));
    #1;
    check("t1_aw_valid", 128'(mst_req.aw_valid), 128'(1'b1));
    check("t1_aw_ready", 128'(slv_resp.aw_ready), 128'(1'b1));
    cyc();
    slv_req.aw_valid = 1'b0; slv_req.w_valid = 1'b0;
    check("t1_wr_cnt_1", 128'(wr_cnt), 128'(3'd1));
    do_b(1'b0, 2'b00);
    check("t1_wr_cnt_0", 128'(wr_cnt), 128'(3'd0));

    // Read cap: four accepted, fifth waits for one R, gate reopens only the cycle after.
    for (int i = 0; i < 4; i++) do_ar(32'h200 + 32'(4 * i));
    check("t2_rd_cnt_4", 128'(rd_cnt), 128'(3'd4));
    slv_req.ar_valid = 1'b1; slv_req.ar.addr = 32'h210;
    exp_ar.push_back(mk_ar(32'h210));
    #1;
    check("t2_ar_ready_full", 128'(slv_resp.ar_ready), 128'(1'b0));
    check("t2_ar_valid_full", 128'(mst_req.ar_valid), 128'(1'b0));
    cyc();
    mst_resp.r_valid = 1'b1; mst_resp.r.data = 32'hA0; mst_resp.r.resp = 2'b00;
    exp_r.push_back({2'b00, 32'hA0});
    #1;
    check("t2_ar_ready_same_cycle_r", 128'(slv_resp.ar_ready), 128'(1'b0));
    cyc();
    mst_resp.r_valid = 1'b0;
    check("t2_rd_cnt_3", 128'(rd_cnt), 128'(3'd3));
    check("t2_ar_ready_reopen", 128'(slv_resp.ar_ready), 128'(1'b1));
    cyc();
    slv_req.ar_valid = 1'b0;
    check("t2_rd_cnt_4b", 128'(rd_cnt), 128'(3'd4));
    slv_req.ar_valid = 1'b1; slv_req.ar.addr = 32'h214;
    #1;
    check("t2_sixth_blocked", 128'(slv_resp.ar_ready), 128'(1'b0));
    slv_req.ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) do_r(32'hB0 + 32'(i), 2'b00, 1'b1);
    check("t2_rd_cnt_drain", 128'(rd_cnt), 128'(3'd0));
    do_ar(32'h214);
    do_r(32'hC0, 2'b01, 1'b1);
    check("t2_rd_cnt_end", 128'(rd_cnt), 128'(3'd0));

    // Write counter: simultaneous AW+B holds, full with B does not reopen same cycle.
    do_write(32'h300, 32'h1);
    do_write(32'h304, 32'h2);
    check("t3_wr_cnt_2", 128'(wr_cnt), 128'(3'd2));
    mst_resp.b_valid = 1'b1; mst_resp.b.resp = 2'b00;
    exp_b.push_back(2'b00);
    do_write(32'h308, 32'h3);
    mst_resp.b_valid = 1'b0;
    check("t3_aw_b_same", 128'(wr_cnt), 128'(3'd2));
    do_write(32'h30C, 32'h4);
    do_write(32'h310, 32'h5);
    check("t3_wr_cnt_full", 128'(wr_cnt), 128'(3'd4));
    slv_req.aw_valid = 1'b1; slv_req.aw.addr = 32'h314;
    slv_req.w_valid  = 1'b1; slv_req.w.data  = 32'h6; slv_req.w.strb = 4'hF;
    exp_aw.push_back(mk_aw(32'h314));
    exp_w.push_back(mk_w(32'h6, 4'hF));
    mst_resp.b_valid = 1'b1; mst_resp.b.resp = 2'b00;
    exp_b.push_back(2'b00);
    #1;
    check("t3_full_aw_ready", 128'(slv_resp.aw_ready), 128'(1'b0));
    check("t3_full_aw_valid", 128'(mst_req.aw_valid), 128'(1'b0));
    cyc();
    mst_resp.b_valid = 1'b0; slv_req.w_valid = 1'b0;
    check("t3_wr_cnt_3", 128'(wr_cnt), 128'(3'd3));
    check("t3_aw_ready_next", 128'(slv_resp.aw_ready), 128'(1'b1));
    cyc();
    slv_req.aw_valid = 1'b0;
    check("t3_wr_cnt_4b", 128'(wr_cnt), 128'(3'd4));
    for (int i = 0; i < 4; i++) do_b(1'b0, 2'b00);
    check("t3_wr_cnt_drain", 128'(wr_cnt), 128'(3'd0));

    // W ahead of AW is forwarded ungated; SLVERR reaches the Lite side.
    mst_resp.w_ready = 1'b0;
    slv_req.w_valid = 1'b1; slv_req.w.data = 32'h12345678; slv_req.w.strb = 4'h3;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_w_early", 128'({mst_req.w_valid, mst_req.w}), 128'({1'b1, mk_w(32'h12345678, 4'h3)}));
      cyc();
    end
    mst_resp.w_ready = 1'b1;
    exp_w.push_back(mk_w(32'h12345678, 4'h3));
    cyc();
    slv_req.w_valid = 1'b0;
    slv_req.aw_valid = 1'b1; slv_req.aw.addr = 32'h400;
    exp_aw.push_back(mk_aw(32'h400));
    cyc();
    slv_req.aw_valid = 1'b0;
    check("t4_wr_cnt_1", 128'(wr_cnt), 128'(3'd1));
    do_b(1'b0, 2'b10);
    check("t4_wr_cnt_0", 128'(wr_cnt), 128'(3'd0));

    // Response checker: R without last, then B with foreign ID; sticky until reset.
    check("t5_err_before", 128'(rsp_err), 128'(1'b0));
    do_ar(32'h500);
    do_r(32'h55, 2'b00, 1'b0);
    check("t5_err_after_r", 128'(rsp_err), 128'(EXP_ERR));
    do_write(32'h504, 32'h77);
    do_b(1'b1, 2'b00);
    cyc();
    cyc();
    check("t5_err_sticky", 128'(rsp_err), 128'(EXP_ERR));
    do_b(1'b0, 2'b00);
    check("t5_b_underflow_cnt", 128'(wr_cnt), 128'(3'd0));
    do_r(32'h66, 2'b00, 1'b1);
    check("t5_r_underflow_cnt", 128'(rd_cnt), 128'(3'd0));

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 3; i++) do_write(32'h600 + 32'(4 * i), 32'(i));
    for (int i = 0; i < 2; i++) do_ar(32'h700 + 32'(4 * i));
    check("t6_wr_cnt_3", 128'(wr_cnt), 128'(3'd3));
    check("t6_rd_cnt_2", 128'(rd_cnt), 128'(3'd2));
    rst = 1'b1;
    #1;
    check("t6_wr_cnt_rst", 128'(wr_cnt), 128'(3'd0));
    check("t6_rd_cnt_rst", 128'(rd_cnt), 128'(3'd0));
    check("t6_err_rst", 128'(rsp_err), 128'(1'b0));
    cyc();
    rst = 1'b0;
    cyc();
    do_write(32'h800, 32'h88);
    check("t6_post_wr_cnt", 128'(wr_cnt), 128'(3'd1));
    do_b(1'b0, 2'b00);
    check("t6_post_wr_cnt_0", 128'(wr_cnt), 128'(3'd0));
    check("t6_post_err", 128'(rsp_err), 128'(1'b0));

    cyc();
    check("leftover_expectations",
          128'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_b.size() + exp_r.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
